dco_nco: RTL and testbench

//  Numerically controlled oscillator closing the digital PLL loop. Consumes the
//  8-bit speed_var control word from the LoopFilter and produces the feedback

---
 rtl/dco_nco_if.sv | 23 ++
 rtl/dco_nco.sv | 137 +++++++++++++
 tb/tb_dco_nco.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dco_nco_if.sv
// Control/observation bundle between the loop filter side and the DCO/NCO.
// The master drives the control word and freeze; the slave (the NCO) drives the feedback outputs.
interface dco_nco_if #(
  parameter int CTRL_W = 8,
  parameter int ACC_W  = 16
);
  logic [CTRL_W-1:0] speed_var;
  logic              freeze;
  logic              fb_clk;
  logic              fb_pulse;
  logic [ACC_W-1:0]  inc;
  logic              locked;

  modport master (
    output speed_var, freeze,
    input  fb_clk, fb_pulse, inc, locked
  );

  modport slave (
    input  speed_var, freeze,
    output fb_clk, fb_pulse, inc, locked
  );
endinterface

// File: rtl/dco_nco.sv
// Digitally controlled oscillator for the PLL feedback path: phase accumulator driven by a
// clamped, gain-scaled increment derived from speed_var, plus a lock detector on the control word.
module dco_nco #(
  parameter int CTRL_W     = 8,
  parameter int ACC_W      = 16,
  parameter int BASE_INC   = 256,
  parameter int GAIN_SHIFT = 2,
  parameter int MIN_INC    = 1,
  parameter int MAX_INC    = 32767,
  parameter int LOCK_TOL   = 2,
  parameter int LOCK_CNT   = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  dco_nco_if.slave  io_nco
);

  localparam int RAW_W = ACC_W + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  localparam logic [CTRL_W-1:0]        CTRL_MID = CTRL_W'(2 ** (CTRL_W - 1));
  localparam logic signed [CTRL_W:0]   OFF_MID  = (CTRL_W + 1)'(2 ** (CTRL_W - 1));
  localparam logic signed [RAW_W-1:0]  BASE_RAW = RAW_W'(BASE_INC);
  localparam logic signed [RAW_W-1:0]  MIN_RAW  = RAW_W'(MIN_INC);
  localparam logic signed [RAW_W-1:0]  MAX_RAW  = RAW_W'(MAX_INC);
  localparam logic [CTRL_W-1:0]        TOL      = CTRL_W'(LOCK_TOL);
  localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(LOCK_CNT);

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lockState_t;

  logic [CTRL_W-1:0]        r_ctrlQ;
  logic [CTRL_W-1:0]        r_ctrlPrev;
  logic [ACC_W-1:0]         r_inc;
  logic [ACC_W-1:0]         r_acc;
  logic                     r_fbClk;
  logic                     r_fbPulse;
  logic [CNT_W-1:0]         r_stableCnt;
  lockState_t               r_state;

  logic signed [CTRL_W:0]   w_off;
  logic signed [RAW_W-1:0]  w_offExt;
  logic signed [RAW_W-1:0]  w_raw;
  logic [ACC_W-1:0]         w_incNext;
  logic [ACC_W-1:0]         w_accNext;
  logic [CTRL_W-1:0]        w_delta;
  logic                     w_stable;
  logic [CNT_W-1:0]         w_cntInc;
  logic [CNT_W-1:0]         w_cntNext;
  lockState_t               w_stateNext;

  // Widened to ACC_W+2 signed bits so the shifted offset and the clamp compare can never overflow.
  always_comb begin
    w_off     = $signed({1'b0, r_ctrlQ}) - OFF_MID;
    w_offExt  = {{(RAW_W - CTRL_W - 1){w_off[CTRL_W]}}, w_off};
    w_raw     = BASE_RAW + (w_offExt <<< GAIN_SHIFT);
    w_incNext = w_raw[ACC_W-1:0];
    if (w_raw < MIN_RAW) begin
      w_incNext = ACC_W'(MIN_INC);
    end else if (w_raw > MAX_RAW) begin
      w_incNext = ACC_W'(MAX_INC);
    end
  end

  assign w_accNext = r_acc + r_inc;
  assign w_delta   = (r_ctrlQ >= r_ctrlPrev) ? (r_ctrlQ - r_ctrlPrev) : (r_ctrlPrev - r_ctrlQ);
  assign w_stable  = (w_delta <= TOL);
  assign w_cntInc  = (r_stableCnt == CNT_MAX) ? r_stableCnt : (r_stableCnt + CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrlQ    <= CTRL_MID;
      r_ctrlPrev <= CTRL_MID;
      r_inc      <= ACC_W'(BASE_INC);
      r_acc      <= '0;
      r_fbClk    <= 1'b0;
      r_fbPulse  <= 1'b0;
    end else begin
      r_ctrlQ    <= io_nco.speed_var;
      r_ctrlPrev <= r_ctrlQ;
      if (!io_nco.freeze) begin
        r_inc <= w_incNext;
      end
      r_acc     <= w_accNext;
      r_fbClk   <= w_accNext[ACC_W-1];
      r_fbPulse <= w_accNext[ACC_W-1] & ~r_acc[ACC_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACQUIRE;
      r_stableCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_stableCnt <= w_cntNext;
    end
  end

  // Lock flag is the state itself, so it changes on the same edge as the transition.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_stableCnt;
    case (r_state)
      ACQUIRE: begin
        if (w_stable) begin
          w_cntNext = w_cntInc;
          if (w_cntInc == CNT_MAX) begin
            w_stateNext = LOCKED;
          end
        end else begin
          w_cntNext = '0;
        end
      end
      LOCKED: begin
        if (w_stable) begin
          w_cntNext = w_cntInc;
        end else begin
          w_stateNext = ACQUIRE;
          w_cntNext   = '0;
        end
      end
      default: begin
        w_stateNext = ACQUIRE;
        w_cntNext   = '0;
      end
    endcase
  end

  assign io_nco.fb_clk   = r_fbClk;
  assign io_nco.fb_pulse = r_fbPulse;
  assign io_nco.inc      = r_inc;
  assign io_nco.locked   = (r_state == LOCKED);

endmodule

// File: tb/tb_dco_nco.sv
// Scoreboard bench for dco_nco: stimulus queues expected values keyed by clock edge count,
// monitors pop and compare on the falling edge and on each fb_pulse.
module tb_dco_nco;

  localparam int SIG_INC    = 0;
  localparam int SIG_LOCKED = 1;
  localparam int SIG_FBCLK  = 2;
  localparam int SIG_PULSE  = 3;

  typedef struct {
    int    cyc;
    int    sig;
    int    lo;
    int    hi;
    string name;
  } chk_t;

  typedef struct {
    int lo;
    int hi;
    bit skip;
  } pulseExp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  int   pulseEpoch;
  int   monEpoch;
  int   lastPulse;

  chk_t      chkQ[$];
  pulseExp_t pulseQ[$];
  chk_t      monE;
  pulseExp_t monP;

  dco_nco_if #(.CTRL_W(8), .ACC_W(16)) nco_if ();

  dco_nco #(
    .CTRL_W(8), .ACC_W(16), .BASE_INC(256), .GAIN_SHIFT(2),
    .MIN_INC(1), .MAX_INC(32767), .LOCK_TOL(2), .LOCK_CNT(16)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_nco (nco_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d..%0d (cyc %0d)", name, act, lo, hi, cyc);
    end
  endtask

  function automatic int sampleSig(input int s);
    case (s)
      SIG_INC:    return int'(nco_if.inc);
      SIG_LOCKED: return int'(nco_if.locked);
      SIG_FBCLK:  return int'(nco_if.fb_clk);
      default:    return int'(nco_if.fb_pulse);
    endcase
  endfunction

  task automatic pushEq(input int c, input int s, input int v, input string n);
    chk_t e;
    int   idx;
    e.cyc = c; e.sig = s; e.lo = v; e.hi = v; e.name = n;
    idx = 0;
    while (idx < chkQ.size() && chkQ[idx].cyc <= c) idx++;
    chkQ.insert(idx, e);
  endtask

  task automatic pushPulse(input int lo, input int hi, input bit skip);
    pulseExp_t p;
    p.lo = lo; p.hi = hi; p.skip = skip;
    pulseQ.push_back(p);
  endtask

  task automatic endPhase(input string name);
    checkOutput({name, "_pulses_pending"}, pulseQ.size(), 0, 0);
    pulseQ.delete();
    pulseEpoch++;
  endtask

  task automatic applyStimulus(input logic [7:0] sv, input logic fz, output int t);
    @(posedge clk);
    #1;
    nco_if.speed_var = sv;
    nco_if.freeze    = fz;
    t = cyc;
  endtask

  // Value monitor: every queued expectation is compared on the falling edge of its cycle.
  always @(negedge clk) begin
    while (chkQ.size() > 0 && chkQ[0].cyc <= cyc) begin
      monE = chkQ.pop_front();
      if (monE.cyc < cyc) checkOutput({monE.name, "_missed"}, cyc, monE.cyc, monE.cyc);
      else checkOutput(monE.name, sampleSig(monE.sig), monE.lo, monE.hi);
    end
  end

  // Pulse monitor: compares spacing between consecutive fb_pulse events.
  always @(negedge clk) begin
    if (nco_if.fb_pulse) begin
      if (monEpoch != pulseEpoch) begin
        monEpoch = pulseEpoch;
      end else if (pulseQ.size() > 0) begin
        monP = pulseQ.pop_front();
        if (!monP.skip) checkOutput("pulse_spacing", cyc - lastPulse, monP.lo, monP.hi);
      end
      lastPulse = cyc;
    end
  end

  initial begin
    int t;
    int tt;
    int t0;
    bit found;
    rst_n = 1'b0;
    nco_if.speed_var = 8'd128;
    nco_if.freeze    = 1'b0;
    monEpoch   = -1;
    pulseEpoch = 0;
    lastPulse  = 0;

    // Centre frequency out of reset
    repeat (3) @(posedge clk);
    #2;
    t0 = cyc;
    rst_n = 1'b1;
    pushEq(t0, SIG_INC, 256, "rst_inc");
    pushEq(t0, SIG_LOCKED, 0, "rst_locked");
    pushEq(t0, SIG_FBCLK, 0, "rst_fbclk");
    pushEq(t0, SIG_PULSE, 0, "rst_pulse");
    pushEq(t0 + 15, SIG_LOCKED, 0, "p1_lock_early");
    pushEq(t0 + 16, SIG_LOCKED, 1, "p1_lock_16");
    pushEq(t0 + 127, SIG_PULSE, 0, "p1_pulse_127");
    pushEq(t0 + 128, SIG_PULSE, 1, "p1_pulse_128");
    pushEq(t0 + 128, SIG_FBCLK, 1, "p1_fbclk_128");
    pushEq(t0 + 129, SIG_PULSE, 0, "p1_pulse_129");
    pushEq(t0 + 255, SIG_FBCLK, 1, "p1_fbclk_255");
    pushEq(t0 + 256, SIG_FBCLK, 0, "p1_fbclk_256");
    pulseEpoch++;
    pushPulse(256, 256, 1'b0);
    pushPulse(256, 256, 1'b0);
    repeat (800) @(posedge clk);
    endPhase("p1");

    // Step 128 -> 160: two-edge latency to inc, lock drops and re-acquires
    applyStimulus(8'd160, 1'b0, t);
    pushEq(t + 1, SIG_INC, 256, "p2_inc_t1");
    pushEq(t + 2, SIG_INC, 384, "p2_inc_t2");
    pushEq(t + 1, SIG_LOCKED, 1, "p2_lock_t1");
    pushEq(t + 2, SIG_LOCKED, 0, "p2_lock_t2");
    pushEq(t + 17, SIG_LOCKED, 0, "p2_lock_t17");
    pushEq(t + 18, SIG_LOCKED, 1, "p2_lock_t18");
    pushPulse(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) pushPulse(170, 171, 1'b0);
    repeat (1100) @(posedge clk);
    endPhase("p2");

    // Top of range
    applyStimulus(8'd255, 1'b0, t);
    pushEq(t + 1, SIG_INC, 384, "p3_inc_t1");
    pushEq(t + 2, SIG_INC, 764, "p3_inc_max");
    pushEq(t + 2, SIG_LOCKED, 0, "p3_lock_t2");
    pushPulse(0, 0, 1'b1);
    for (int i = 0; i < 4; i++) pushPulse(85, 86, 1'b0);
    repeat (600) @(posedge clk);
    endPhase("p3");

    // Alternating 130/131 stays within tolerance; 140 breaks lock and clears the count
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 2 == 0) ? 8'd130 : 8'd131, 1'b0, tt);
      if (i == 0) begin
        t = tt;
        pushEq(t + 1, SIG_LOCKED, 1, "p4_lock_t1");
        pushEq(t + 2, SIG_LOCKED, 0, "p4_lock_t2");
        pushEq(t + 2, SIG_INC, 264, "p4_inc_130");
        pushEq(t + 3, SIG_INC, 268, "p4_inc_131");
        pushEq(t + 17, SIG_LOCKED, 0, "p4_lock_t17");
        pushEq(t + 18, SIG_LOCKED, 1, "p4_lock_t18");
      end
    end
    applyStimulus(8'd140, 1'b0, tt);
    pushEq(tt + 1, SIG_LOCKED, 1, "p4_lock_pre140");
    pushEq(tt + 2, SIG_LOCKED, 0, "p4_lock_140");
    pushEq(tt + 2, SIG_INC, 304, "p4_inc_140");
    pushEq(tt + 17, SIG_LOCKED, 0, "p4_relock_early");
    pushEq(tt + 18, SIG_LOCKED, 1, "p4_relock");
    repeat (40) @(posedge clk);
    endPhase("p4");

    // Freeze holds inc while the lock detector keeps tracking
    applyStimulus(8'd128, 1'b0, t);
    repeat (40) @(posedge clk);
    applyStimulus(8'd200, 1'b1, t);
    pushEq(t + 1, SIG_LOCKED, 1, "p5_lock_t1");
    pushEq(t + 2, SIG_LOCKED, 0, "p5_lock_t2");
    pushEq(t + 2, SIG_INC, 256, "p5_inc_frozen_t2");
    pushEq(t + 5, SIG_INC, 256, "p5_inc_frozen_t5");
    pushEq(t + 17, SIG_LOCKED, 0, "p5_lock_t17");
    pushEq(t + 18, SIG_LOCKED, 1, "p5_lock_t18");
    for (int i = 0; i < 9; i++) applyStimulus(8'd200, 1'b1, tt);
    applyStimulus(8'd200, 1'b0, tt);
    pushEq(tt, SIG_INC, 256, "p5_inc_still_frozen");
    pushEq(tt + 1, SIG_INC, 544, "p5_inc_released");
    repeat (40) @(posedge clk);
    endPhase("p5");

    // Asynchronous reset mid-cycle while fb_clk and locked are high
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #2;
      if (nco_if.fb_clk && nco_if.locked) found = 1'b1;
    end
    checkOutput("p6_precondition", int'(found), 1, 1);
    rst_n = 1'b0;
    pushEq(cyc, SIG_FBCLK, 0, "p6_async_fbclk");
    pushEq(cyc, SIG_PULSE, 0, "p6_async_pulse");
    pushEq(cyc, SIG_LOCKED, 0, "p6_async_locked");
    pushEq(cyc, SIG_INC, 256, "p6_async_inc");
    nco_if.speed_var = 8'd0;
    repeat (3) @(posedge clk);
    endPhase("p6");

    // Bottom of range: increment clamps to 1, MSB rises after a long ramp
    #2;
    t0 = cyc;
    rst_n = 1'b1;
    pushEq(t0 + 1, SIG_INC, 256, "p7_inc_t1");
    pushEq(t0 + 2, SIG_INC, 1, "p7_inc_min");
    pushEq(t0 + 32257, SIG_FBCLK, 0, "p7_fbclk_before");
    pushEq(t0 + 32257, SIG_PULSE, 0, "p7_pulse_before");
    pushEq(t0 + 32258, SIG_FBCLK, 1, "p7_fbclk_rise");
    pushEq(t0 + 32258, SIG_PULSE, 1, "p7_pulse_rise");
    pushEq(t0 + 32259, SIG_PULSE, 0, "p7_pulse_after");
    pushEq(t0 + 32259, SIG_INC, 1, "p7_inc_hold");
    repeat (32270) @(posedge clk);
    endPhase("p7");

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", chkQ.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
